// File: rtl/multi_voice_engine.sv
// Time-multiplexed tone generator: per-channel phase accumulators, four waveforms,
// amplitude scaling and a summing mixer that services one channel per clock.
module multi_voice_engine #(
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_WIDTH  = 32,
  parameter int AMP_WIDTH    = 4,
  localparam int CHAN_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int OUT_WIDTH   = AMP_WIDTH + CHAN_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tick_stb,
  input  logic                   i_sample_stb,
  input  logic                   i_cfg_we,
  input  logic [CHAN_BITS-1:0]   i_cfg_chan,
  input  logic [PHASE_WIDTH-1:0] i_cfg_delta,
  input  logic [AMP_WIDTH-1:0]   i_cfg_amp,
  input  logic [1:0]             i_cfg_mode,
  input  logic                   i_cfg_phase_rst,
  output logic [OUT_WIDTH-1:0]   o_sample,
  output logic                   o_sample_valid,
  output logic                   o_busy,
  output logic                   o_overrun
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_NOISE  = 2'd3;
  localparam logic [CHAN_BITS-1:0] LAST_CH   = CHAN_BITS'(NUM_CHANNELS - 1);
  localparam logic [14:0]          LFSR_SEED = 15'h0001;

  function automatic logic [14:0] lfsr_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  function automatic logic [AMP_WIDTH-1:0] calc_contrib(
    input logic [PHASE_WIDTH-1:0] ph,
    input logic [AMP_WIDTH-1:0]   amp,
    input logic [1:0]             mode,
    input logic [14:0]            lfsr
  );
    logic [AMP_WIDTH-1:0]   lvl;
    logic [2*AMP_WIDTH-1:0] prod;
    case (mode)
      MODE_SAW:   lvl = ph[PHASE_WIDTH-1 -: AMP_WIDTH];
      MODE_TRI:   lvl = ph[PHASE_WIDTH-1] ? ~ph[PHASE_WIDTH-2 -: AMP_WIDTH]
                                          :  ph[PHASE_WIDTH-2 -: AMP_WIDTH];
      MODE_NOISE: lvl = lfsr[AMP_WIDTH-1:0];
      default:    lvl = '0;
    endcase
    prod = (2*AMP_WIDTH)'(lvl) * (2*AMP_WIDTH)'(amp);
    if (mode == MODE_SQUARE) begin
      return ph[PHASE_WIDTH-1] ? amp : '0;
    end else begin
      return prod[2*AMP_WIDTH-1 -: AMP_WIDTH];
    end
  endfunction

  logic [PHASE_WIDTH-1:0] sh_delta_q  [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] sh_delta_d  [NUM_CHANNELS];
  logic [AMP_WIDTH-1:0]   sh_amp_q    [NUM_CHANNELS];
  logic [AMP_WIDTH-1:0]   sh_amp_d    [NUM_CHANNELS];
  logic [1:0]             sh_mode_q   [NUM_CHANNELS];
  logic [1:0]             sh_mode_d   [NUM_CHANNELS];
  logic                   sh_prst_q   [NUM_CHANNELS];
  logic                   sh_prst_d   [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] act_delta_q [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] act_delta_d [NUM_CHANNELS];
  logic [AMP_WIDTH-1:0]   act_amp_q   [NUM_CHANNELS];
  logic [AMP_WIDTH-1:0]   act_amp_d   [NUM_CHANNELS];
  logic [1:0]             act_mode_q  [NUM_CHANNELS];
  logic [1:0]             act_mode_d  [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] phase_q     [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] phase_d     [NUM_CHANNELS];

  state_e                 state_q, state_d;
  logic [CHAN_BITS-1:0]   ch_q, ch_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [14:0]            lfsr_q, lfsr_d;
  logic [OUT_WIDTH-1:0]   sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   pending_q, pending_d;

  logic                   commit_s;
  logic                   run_s;
  logic                   carry_s;
  logic [PHASE_WIDTH-1:0] ph_new_s;
  logic [AMP_WIDTH-1:0]   contrib_s;

  // Commit only while idle so a sample in flight always sees one consistent config.
  assign commit_s  = (state_q == ST_IDLE) && pending_q;
  assign run_s     = (state_q == ST_RUN);
  assign pending_d = i_tick_stb | (pending_q & ~commit_s);
  assign {carry_s, ph_new_s} = {1'b0, phase_q[ch_q]} + {1'b0, act_delta_q[ch_q]};
  assign contrib_s = calc_contrib(ph_new_s, act_amp_q[ch_q], act_mode_q[ch_q], lfsr_q);

  // Shadow writes, shadow-to-active commit and per-channel phase update.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      logic wr;
      wr = i_cfg_we && (i_cfg_chan == CHAN_BITS'(i));
      sh_delta_d[i]  = wr ? i_cfg_delta : sh_delta_q[i];
      sh_amp_d[i]    = wr ? i_cfg_amp   : sh_amp_q[i];
      sh_mode_d[i]   = wr ? i_cfg_mode  : sh_mode_q[i];
      sh_prst_d[i]   = wr ? i_cfg_phase_rst : (commit_s ? 1'b0 : sh_prst_q[i]);
      act_delta_d[i] = commit_s ? sh_delta_q[i] : act_delta_q[i];
      act_amp_d[i]   = commit_s ? sh_amp_q[i]   : act_amp_q[i];
      act_mode_d[i]  = commit_s ? sh_mode_q[i]  : act_mode_q[i];
      phase_d[i]     = (commit_s && sh_prst_q[i])            ? '0       :
                       (run_s && (ch_q == CHAN_BITS'(i)))    ? ph_new_s : phase_q[i];
    end
  end

  // Sample sequencer: IDLE -> RUN (one channel per cycle) -> DONE.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    acc_d    = acc_q;
    lfsr_d   = lfsr_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_sample_stb) begin
          state_d = ST_RUN;
          ch_d    = '0;
          acc_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + OUT_WIDTH'(contrib_s);
        if (carry_s && (act_mode_q[ch_q] == MODE_NOISE)) begin
          lfsr_d = lfsr_step(lfsr_q);
        end else begin
          lfsr_d = lfsr_q;
        end
        if (ch_q == LAST_CH) begin
          state_d = ST_DONE;
        end else begin
          ch_d = ch_q + CHAN_BITS'(1);
        end
      end
      ST_DONE: begin
        sample_d = acc_q;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d    = (state_d != ST_IDLE);
    overrun_d = i_sample_stb && (state_q != ST_IDLE);
  end

  // State, configuration and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        sh_delta_q[i]  <= '0;
        sh_amp_q[i]    <= '0;
        sh_mode_q[i]   <= '0;
        sh_prst_q[i]   <= 1'b0;
        act_delta_q[i] <= '0;
        act_amp_q[i]   <= '0;
        act_mode_q[i]  <= '0;
        phase_q[i]     <= '0;
      end
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      acc_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        sh_delta_q[i]  <= sh_delta_d[i];
        sh_amp_q[i]    <= sh_amp_d[i];
        sh_mode_q[i]   <= sh_mode_d[i];
        sh_prst_q[i]   <= sh_prst_d[i];
        act_delta_q[i] <= act_delta_d[i];
        act_amp_q[i]   <= act_amp_d[i];
        act_mode_q[i]  <= act_mode_d[i];
        phase_q[i]     <= phase_d[i];
      end
      state_q   <= state_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      lfsr_q    <= lfsr_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
    end
  end

  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;
  assign o_busy         = busy_q;
  assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_multi_voice_engine.sv
// Bench for multi_voice_engine: constant vector table, hand-written corner sequences
// and random traffic checked against a transaction-level model.
module tb_multi_voice_engine;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  chan = 2'd0;
  logic [31:0] delta = 32'd0;
  logic [3:0]  amp = 4'd0;
  logic [1:0]  mode = 2'd0;
  logic        prst = 1'b0;
  logic [5:0]  sample;
  logic        valid, busy, ovr;

  always #5 clk = ~clk;

  multi_voice_engine #(.NUM_CHANNELS(N), .PHASE_WIDTH(32), .AMP_WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick_stb(tick), .i_sample_stb(stb),
    .i_cfg_we(we), .i_cfg_chan(chan), .i_cfg_delta(delta), .i_cfg_amp(amp),
    .i_cfg_mode(mode), .i_cfg_phase_rst(prst),
    .o_sample(sample), .o_sample_valid(valid), .o_busy(busy), .o_overrun(ovr)
  );

  int vec_cnt = 0;
  int miss_cnt = 0;

  // Transaction-level model state
  logic [31:0]     m_sh_delta [N];
  int              m_sh_amp [N];
  int              m_sh_mode [N];
  bit              m_sh_prst [N];
  logic [31:0]     m_act_delta [N];
  int              m_act_amp [N];
  int              m_act_mode [N];
  longint unsigned m_phase [N];
  int unsigned     m_lfsr;
  bit              m_pending;

  typedef struct {
    int          ch;
    int          mode;
    int          amp;
    logic [31:0] delta;
    int          k;
    int          exp;
  } vec_t;
  vec_t tbl [16];
  int   exp2 [4] = '{0, 9, 9, 0};

  int obs_vcnt, obs_vfirst, obs_ovr, obs_sample;

  task automatic check(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int c = 0; c < N; c++) begin
      m_sh_delta[c] = 32'd0; m_sh_amp[c] = 0; m_sh_mode[c] = 0; m_sh_prst[c] = 1'b0;
      m_act_delta[c] = 32'd0; m_act_amp[c] = 0; m_act_mode[c] = 0; m_phase[c] = 64'd0;
    end
    m_lfsr = 32'd1;
    m_pending = 1'b0;
  endfunction

  function automatic void m_write(input int c, input logic [31:0] d, input int a, input int md, input bit p);
    m_sh_delta[c] = d; m_sh_amp[c] = a; m_sh_mode[c] = md; m_sh_prst[c] = p;
  endfunction

  function automatic void m_commit();
    for (int c = 0; c < N; c++) begin
      m_act_delta[c] = m_sh_delta[c];
      m_act_amp[c]   = m_sh_amp[c];
      m_act_mode[c]  = m_sh_mode[c];
      if (m_sh_prst[c]) m_phase[c] = 64'd0;
      m_sh_prst[c] = 1'b0;
    end
  endfunction

  // One mixed sample: advance each phase in turn, derive its level, scale and sum.
  function automatic int m_sample();
    int sum;
    sum = 0;
    for (int c = 0; c < N; c++) begin
      longint unsigned s;
      bit carry;
      int lvl, seg, contrib;
      s = m_phase[c] + {32'd0, m_act_delta[c]};
      carry = (s >= 64'h1_0000_0000);
      m_phase[c] = s % 64'h1_0000_0000;
      lvl = 0;
      case (m_act_mode[c])
        0: lvl = 0;
        1: lvl = int'(m_phase[c] / 64'h1000_0000);
        2: begin
          seg = int'(m_phase[c] / 64'h0800_0000);
          lvl = (seg < 16) ? seg : 31 - seg;
        end
        default: lvl = int'(m_lfsr % 16);
      endcase
      if (m_act_mode[c] == 0) contrib = (m_phase[c] >= 64'h8000_0000) ? m_act_amp[c] : 0;
      else contrib = (lvl * m_act_amp[c]) / 16;
      if (m_act_mode[c] == 3 && carry)
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7FFF;
      sum += contrib;
    end
    return sum;
  endfunction

  task automatic observe(input int n);
    obs_vcnt = 0; obs_vfirst = 0; obs_ovr = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (valid) begin
        obs_vcnt++;
        if (obs_vfirst == 0) obs_vfirst = i;
        obs_sample = int'(sample);
      end
      if (ovr) obs_ovr++;
    end
  endtask

  task automatic cfg_write(input int c, input logic [31:0] d, input int a, input int md, input bit p);
    we = 1'b1; chan = 2'(c); delta = d; amp = 4'(a); mode = 2'(md); prst = p;
    step();
    we = 1'b0; prst = 1'b0;
    m_write(c, d, a, md, p);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    m_commit();
  endtask

  task automatic do_sample(output int got);
    int exp;
    exp = m_sample();
    stb = 1'b1;
    step();
    stb = 1'b0;
    check("busy_after_strobe", busy, 1);
    observe(N + 2);
    check("valid_count", obs_vcnt, 1);
    check("latency", obs_vfirst, N + 1);
    check("sample_vs_model", obs_sample, exp);
    got = obs_sample;
    if (m_pending) begin
      m_commit();
      m_pending = 1'b0;
    end
  endtask

  task automatic setup_single(input int ch, input int md, input int a, input logic [31:0] d);
    for (int c = 0; c < N; c++) cfg_write(c, 32'd0, 0, 0, 1'b1);
    cfg_write(ch, d, a, md, 1'b1);
    do_tick();
  endtask

  initial begin
    int got, exp;
    tbl[0]  = '{0, 0, 9,  32'h4000_0000, 1,  0};
    tbl[1]  = '{0, 0, 9,  32'h4000_0000, 2,  9};
    tbl[2]  = '{0, 0, 9,  32'h4000_0000, 3,  9};
    tbl[3]  = '{0, 0, 9,  32'h4000_0000, 4,  0};
    tbl[4]  = '{0, 1, 15, 32'h1000_0000, 1,  0};
    tbl[5]  = '{0, 1, 15, 32'h1000_0000, 5,  4};
    tbl[6]  = '{0, 1, 15, 32'h1000_0000, 15, 14};
    tbl[7]  = '{0, 1, 15, 32'h1000_0000, 16, 0};
    tbl[8]  = '{0, 2, 15, 32'h0800_0000, 15, 14};
    tbl[9]  = '{0, 2, 15, 32'h0800_0000, 16, 14};
    tbl[10] = '{0, 2, 15, 32'h0800_0000, 17, 13};
    tbl[11] = '{0, 2, 15, 32'h0800_0000, 31, 0};
    tbl[12] = '{2, 0, 7,  32'h8000_0000, 1,  7};
    tbl[13] = '{3, 1, 8,  32'h3000_0000, 2,  3};
    tbl[14] = '{1, 0, 0,  32'h8000_0000, 1,  0};
    tbl[15] = '{3, 2, 5,  32'h6000_0000, 1,  3};

    // Reset held with strobes toggling
    m_reset();
    for (int i = 0; i < 6; i++) begin
      tick = (i % 2 == 1); stb = (i % 2 == 0); we = 1'b1;
      step();
      check("reset_outputs", {sample, valid, busy, ovr}, 0);
    end
    tick = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    observe(6);
    check("post_reset_valid", obs_vcnt, 0);
    check("post_reset_busy", busy, 0);

    // Square on ch0, strobes eight cycles apart
    setup_single(0, 0, 9, 32'h4000_0000);
    for (int k = 0; k < 4; k++) begin
      do_sample(got);
      check("square_seq", got, exp2[k]);
      step();
    end

    // Constant vector table
    for (int i = 0; i < 16; i++) begin
      setup_single(tbl[i].ch, tbl[i].mode, tbl[i].amp, tbl[i].delta);
      for (int k = 0; k < tbl[i].k; k++) do_sample(got);
      check($sformatf("table_%0d", i), got, tbl[i].exp);
    end

    // All four channels at full-scale square
    for (int c = 0; c < N; c++) cfg_write(c, 32'h8000_0000, 15, 0, 1'b1);
    do_tick();
    for (int k = 0; k < 3; k++) begin
      do_sample(got);
      check("full_scale_mix", got, (k % 2 == 0) ? 60 : 0);
    end

    // Config write plus tick while a sample is running
    setup_single(1, 1, 3, 32'hF000_0000);
    exp = m_sample();
    stb = 1'b1;
    step();
    stb = 1'b0;
    we = 1'b1; chan = 2'd1; delta = 32'hF000_0000; amp = 4'd7; mode = 2'd1; prst = 1'b0; tick = 1'b1;
    step();
    we = 1'b0; tick = 1'b0;
    m_write(1, 32'hF000_0000, 7, 1, 1'b0);
    m_pending = 1'b1;
    observe(N + 1);
    check("midrun_valid_count", obs_vcnt, 1);
    check("midrun_old_amp", obs_sample, 2);
    check("midrun_vs_model", obs_sample, exp);
    m_commit();
    m_pending = 1'b0;
    do_sample(got);
    check("new_amp", got, 6);
    cfg_write(1, 32'hF000_0000, 7, 1, 1'b1);
    do_tick();
    do_sample(got);
    check("phase_rst", got, 6);

    // Strobe while busy
    setup_single(0, 0, 9, 32'h4000_0000);
    exp = m_sample();
    stb = 1'b1; step(); stb = 1'b0;
    step();
    stb = 1'b1; step(); stb = 1'b0;
    check("overrun_pulse", ovr, 1);
    observe(N);
    check("overrun_valid_count", obs_vcnt, 1);
    check("overrun_sample", obs_sample, exp);
    check("overrun_single_pulse", obs_ovr, 0);

    // Reset during RUN
    stb = 1'b1; step(); stb = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {sample, valid, busy, ovr}, 0);
    step(); step();
    rst_n = 1'b1;
    observe(8);
    check("midrun_reset_no_valid", obs_vcnt, 0);
    check("midrun_reset_busy", busy, 0);
    m_reset();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op <= 2) cfg_write($urandom_range(0, N - 1), $urandom, $urandom_range(0, 15),
                             $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      else if (op == 3) do_tick();
      else do_sample(got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec_cnt);
    $fatal(1);
  end

endmodule
